// File: rtl/sort_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sort_arb_pkg
//  Description : Shared lane geometry, FSM state encoding and a lane
//                extraction helper for the sort_arbiter block.
//  Revision    : 1.0 - initial release
// ============================================================================
package sort_arb_pkg;

    localparam int LANE_W = 8;
    localparam int NLANE  = 6;
    localparam int BUS_W  = NLANE * LANE_W;   // 48

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Extract 8-bit lane i (lane 0 = least significant byte) from a packed bus.
    function automatic logic [LANE_W-1:0] lane(input logic [BUS_W-1:0] bus,
                                               input int unsigned      i);
        return bus[i*LANE_W +: LANE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans req upward from ptr
//                with wrap-around and reports the first set requester.
//  Ports       : req [NREQ]  - request vector
//                ptr [IDX_W] - highest-priority requester index
//                win [NREQ]  - one-hot winner (0 when no request)
//                idx [IDX_W] - binary winner index
//                any         - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Offsets are visited from farthest to nearest so the requester closest
    // to ptr is the last one written and therefore wins.
    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            for (int k = 0; k < NREQ; k++) begin
                if (((k == i + int'(ptr)) || (k == i + int'(ptr) - NREQ)) && req[k]) begin
                    win    = '0;
                    win[k] = 1'b1;
                    idx    = IDX_W'(k);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sort_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sort_arbiter
//  Description : Shares one external 6-lane sort unit between NREQ
//                requesters. Jobs are granted round-robin, the sorter is
//                driven from registers, and the sorted result is sampled
//                SORT_LAT+1 cycles after the sorter inputs update and returned
//                to the job owner with a one-cycle rsp_valid pulse.
//  Config      : SORT_ARB_LOCK_EN - adds req_lock; a locked owner that still
//                requests keeps priority for its next job.
//  Ports       : clk, reset (async, active-low)
//                req/req_aid/req_cnt   - per-requester job request and data
//                req_lock              - per-requester lock (SORT_ARB_LOCK_EN)
//                gnt                   - one-hot grant pulse
//                rsp_valid/rsp_aid/rsp_cnt - response pulse and held result
//                busy                  - job in flight
//                in_Aid_all/in_CNT_all - registered sorter inputs
//                out_Aid_all/out_CNT_all - sorter outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module sort_arbiter
    import sort_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int SORT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*BUS_W-1:0] req_aid,
    input  logic [NREQ*BUS_W-1:0] req_cnt,
`ifdef SORT_ARB_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [BUS_W-1:0]      rsp_aid,
    output logic [BUS_W-1:0]      rsp_cnt,
    output logic                  busy,
    output logic [BUS_W-1:0]      in_Aid_all,
    output logic [BUS_W-1:0]      in_CNT_all,
    input  logic [BUS_W-1:0]      out_Aid_all,
    input  logic [BUS_W-1:0]      out_CNT_all
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic [IDX_W-1:0]   owner_q,     owner_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [NREQ-1:0]    gnt_q,       gnt_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [BUS_W-1:0]   rsp_aid_q,   rsp_aid_d;
    logic [BUS_W-1:0]   rsp_cnt_q,   rsp_cnt_d;
    logic               busy_q,      busy_d;
    logic [BUS_W-1:0]   in_aid_q,    in_aid_d;
    logic [BUS_W-1:0]   in_cnt_q,    in_cnt_d;

    logic [NREQ-1:0]    pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [BUS_W-1:0]   job_aid;
    logic [BUS_W-1:0]   job_cnt;
    logic [IDX_W-1:0]   ptr_next;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Winner's job data, selected by the one-hot pick.
    always_comb begin
        job_aid = '0;
        job_cnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_win[k]) begin
                job_aid = req_aid[k*BUS_W +: BUS_W];
                job_cnt = req_cnt[k*BUS_W +: BUS_W];
            end
        end
    end

    // Round-robin successor of the current owner.
    always_comb begin
        ptr_next = '0;
        if (owner_q != IDX_W'(NREQ - 1)) begin
            ptr_next = owner_q + IDX_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        rsp_aid_d   = rsp_aid_q;
        rsp_cnt_d   = rsp_cnt_q;
        busy_d      = busy_q;
        in_aid_d    = in_aid_q;
        in_cnt_d    = in_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_win;
                    in_aid_d = job_aid;
                    in_cnt_d = job_cnt;
                    owner_d  = pick_idx;
                    cnt_d    = CNT_W'(SORT_LAT);
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // The first WAIT cycle is already one cycle after in_* update,
                // so a zero count samples a combinational sorter directly.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_aid_d = out_Aid_all;
                    rsp_cnt_d = out_CNT_all;
                    state_d   = RESP;
                end
            end
            RESP: begin
                for (int k = 0; k < NREQ; k++) begin
                    rsp_valid_d[k] = (owner_q == IDX_W'(k));
                end
                ptr_d   = ptr_next;
`ifdef SORT_ARB_LOCK_EN
                // Keeping ptr on the owner makes it first in line next IDLE.
                if (req_lock[owner_q] && req[owner_q]) begin
                    ptr_d = owner_q;
                end
`endif
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_aid_q   <= '0;
            rsp_cnt_q   <= '0;
            busy_q      <= 1'b0;
            in_aid_q    <= '0;
            in_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_aid_q   <= rsp_aid_d;
            rsp_cnt_q   <= rsp_cnt_d;
            busy_q      <= busy_d;
            in_aid_q    <= in_aid_d;
            in_cnt_q    <= in_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_aid    = rsp_aid_q;
    assign rsp_cnt    = rsp_cnt_q;
    assign busy       = busy_q;
    assign in_Aid_all = in_aid_q;
    assign in_CNT_all = in_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sort_arbiter
//  Description : Self-checking bench for sort_arbiter with a lane-reversing
//                sorter model delayed by SLAT cycles. Expected responses are
//                queued at grant time and compared when rsp_valid pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_arbiter;
    import sort_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int SLAT = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*BUS_W-1:0] req_aid;
    logic [NREQ*BUS_W-1:0] req_cnt;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [BUS_W-1:0]      rsp_aid;
    logic [BUS_W-1:0]      rsp_cnt;
    logic                  busy;
    logic [BUS_W-1:0]      in_Aid_all;
    logic [BUS_W-1:0]      in_CNT_all;
    logic [BUS_W-1:0]      out_Aid_all;
    logic [BUS_W-1:0]      out_CNT_all;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int tb_ptr   = 0;

    typedef struct {
        logic [NREQ-1:0]  who;
        logic [BUS_W-1:0] aid;
        logic [BUS_W-1:0] cnt;
        int               due;
    } exp_t;
    exp_t sb_q[$];

    sort_arbiter #(
        .NREQ     (NREQ),
        .SORT_LAT (SLAT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_aid     (req_aid),
        .req_cnt     (req_cnt),
`ifdef SORT_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_aid     (rsp_aid),
        .rsp_cnt     (rsp_cnt),
        .busy        (busy),
        .in_Aid_all  (in_Aid_all),
        .in_CNT_all  (in_CNT_all),
        .out_Aid_all (out_Aid_all),
        .out_CNT_all (out_CNT_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [BUS_W-1:0] rev(input logic [BUS_W-1:0] b);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int i = 0; i < NLANE; i++) begin
            r[i*LANE_W +: LANE_W] = lane(b, NLANE - 1 - i);
        end
        return r;
    endfunction

    // Sorter model: reverse lanes, output delayed SLAT cycles after in_* change.
    if (SLAT == 0) begin : g_sort_comb
        assign out_Aid_all = rev(in_Aid_all);
        assign out_CNT_all = rev(in_CNT_all);
    end else begin : g_sort_pipe
        logic [BUS_W-1:0] pa [SLAT];
        logic [BUS_W-1:0] pc [SLAT];
        always @(posedge clk) begin
            pa[0] <= rev(in_Aid_all);
            pc[0] <= rev(in_CNT_all);
            for (int i = 1; i < SLAT; i++) begin
                pa[i] <= pa[i-1];
                pc[i] <= pc[i-1];
            end
        end
        assign out_Aid_all = pa[SLAT-1];
        assign out_CNT_all = pc[SLAT-1];
    end

    task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Response scoreboard: every rsp_valid pulse must match the oldest queued job.
    always @(negedge clk) begin
        if (reset && rsp_valid != '0) begin
            if (sb_q.size() == 0) begin
                chk_val("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk_val("rsp_valid", 64'(rsp_valid), 64'(e.who));
                chk_val("rsp_aid",   64'(rsp_aid),   64'(e.aid));
                chk_val("rsp_cnt",   64'(rsp_cnt),   64'(e.cnt));
                chk_val("rsp_cycle", 64'(cyc),       64'(e.due));
            end
        end
    end

    function automatic logic [NREQ-1:0] rr_exp(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] res;
        logic            found;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (p + i) % NREQ;
            if (!found && r[k]) begin
                res[k] = 1'b1;
                found  = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic set_job(input int k, input logic [BUS_W-1:0] aid, input logic [BUS_W-1:0] cnt);
        req_aid[k*BUS_W +: BUS_W] = aid;
        req_cnt[k*BUS_W +: BUS_W] = cnt;
    endtask

    function automatic logic [BUS_W-1:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    task automatic wait_gnt(output logic [NREQ-1:0] g, output int gc);
        g  = '0;
        gc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g  = gnt;
                gc = cyc;
                return;
            end
        end
        chk_val("gnt_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64; i++) begin
            if (sb_q.size() == 0) return;
            @(negedge clk);
        end
        chk_val("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    // Waits for a grant, checks it against exp_g and queues the expected response.
    task automatic expect_job(input logic [NREQ-1:0] exp_g, output int gc);
        logic [NREQ-1:0] g;
        exp_t            e;
        int              w;
        wait_gnt(g, gc);
        w = oh_idx(exp_g);
        chk_val("gnt",         64'(g),          64'(exp_g));
        chk_val("busy_at_gnt", 64'(busy),       64'd1);
        chk_val("in_aid",      64'(in_Aid_all), 64'(req_aid[w*BUS_W +: BUS_W]));
        chk_val("in_cnt",      64'(in_CNT_all), 64'(req_cnt[w*BUS_W +: BUS_W]));
        e.who = exp_g;
        e.aid = rev(req_aid[w*BUS_W +: BUS_W]);
        e.cnt = rev(req_cnt[w*BUS_W +: BUS_W]);
        e.due = gc + SLAT + 2;
        sb_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_gnt"},  64'(gnt),        64'd0);
        chk_val({tag, "_rspv"}, 64'(rsp_valid),  64'd0);
        chk_val({tag, "_raid"}, 64'(rsp_aid),    64'd0);
        chk_val({tag, "_rcnt"}, 64'(rsp_cnt),    64'd0);
        chk_val({tag, "_busy"}, 64'(busy),       64'd0);
        chk_val({tag, "_iaid"}, 64'(in_Aid_all), 64'd0);
        chk_val({tag, "_icnt"}, 64'(in_CNT_all), 64'd0);
    endtask

    initial begin
        logic [NREQ-1:0] e;
        int gc, prev_gc, c0;

        reset    = 1'b0;
        req      = '0;
        req_aid  = '0;
        req_cnt  = '0;
        req_lock = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single job from requester 0 with known lane pattern.
        set_job(0, 48'h010203040506, 48'h0A0B0C0D0E0F);
        req = 2'b01;
        c0  = cyc;
        expect_job(2'b01, gc);
        req = '0;
        chk_val("req_to_gnt", 64'(gc - c0), 64'd1);
        chk_val("rev_const", 64'(rev(48'h010203040506)), 64'h060504030201);
        tb_ptr = 1;
        wait_drain();

        // Reset during the second WAIT cycle discards the job.
        set_job(0, rnd48(), rnd48());
        req = 2'b01;
        wait_gnt(e, gc);
        chk_val("mid_gnt", 64'(e), 64'(rr_exp(2'b01, tb_ptr)));
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        reset  = 1'b1;
        tb_ptr = 0;
        repeat (SLAT + 6) @(negedge clk);
        chk_val("midrst_busy", 64'(busy), 64'd0);

        // Both requesters held: strict alternation, back-to-back throughput.
        set_job(0, rnd48(), rnd48());
        set_job(1, rnd48(), rnd48());
        req     = 2'b11;
        prev_gc = 0;
        for (int j = 0; j < 4; j++) begin
            int w;
            e = rr_exp(req, tb_ptr);
            chk_val("alt_pattern", 64'(e), (j % 2 == 0) ? 64'd1 : 64'd2);
            expect_job(e, gc);
            if (j > 0) chk_val("b2b_interval", 64'(gc - prev_gc), 64'(SLAT + 3));
            prev_gc = gc;
            w       = oh_idx(e);
            tb_ptr  = (w + 1) % NREQ;
            set_job(w, rnd48(), rnd48());
            if (j == 3) req = '0;
        end
        wait_drain();

        // Random single-shot request patterns.
        for (int j = 0; j < 6; j++) begin
            set_job(0, rnd48(), rnd48());
            set_job(1, rnd48(), rnd48());
            req = NREQ'($urandom_range(1, 3));
            c0  = cyc;
            e   = rr_exp(req, tb_ptr);
            expect_job(e, gc);
            req = '0;
            chk_val("rnd_req_to_gnt", 64'(gc - c0), 64'd1);
            tb_ptr = (oh_idx(e) + 1) % NREQ;
            wait_drain();
        end

        // Requester 1 drops req right after its grant; response still issued.
        set_job(1, rnd48(), rnd48());
        req = 2'b10;
        expect_job(2'b10, gc);
        req    = '0;
        tb_ptr = 0;
        wait_drain();
        @(negedge clk);
        chk_val("drop_busy_after", 64'(busy), 64'd0);
        chk_val("drop_no_gnt",     64'(gnt),  64'd0);

`ifdef SORT_ARB_LOCK_EN
        // Locked owner keeps the grant until the lock is released.
        set_job(0, rnd48(), rnd48());
        set_job(1, rnd48(), rnd48());
        req      = 2'b11;
        req_lock = 2'b01;
        for (int j = 0; j < 4; j++) begin
            int w;
            e = rr_exp(req, tb_ptr);
            chk_val("lock_pattern", 64'(e), (j < 3) ? 64'd1 : 64'd2);
            expect_job(e, gc);
            w = oh_idx(e);
            if (j == 2) req_lock = '0;
            tb_ptr = (req_lock[w] && req[w]) ? w : (w + 1) % NREQ;
            set_job(w, rnd48(), rnd48());
            if (j == 3) req = '0;
        end
        wait_drain();
`endif

        repeat (3) @(negedge clk);
        chk_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
